// File: rtl/exu_muldiv.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// STEP bits retired per cycle, with single-cycle divide-by-zero/overflow results.
module exu_muldiv #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned STEP  = 1,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned CntW    = $clog2(XLEN);
  localparam int unsigned NFull   = XLEN / STEP;
  localparam int unsigned NWord   = 32 / STEP;
  localparam logic [CntW-1:0] CntFull = CntW'(NFull - 1);
  localparam logic [CntW-1:0] CntWord = CntW'(NWord - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MinNegW = XLEN'($signed(32'h8000_0000));

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                word_q, word_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [TAG_W-1:0]    tag_q, tag_d;

  function automatic logic [XLEN-1:0] wsext(input logic [XLEN-1:0] v, input logic w);
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  // Operand preprocessing for the accept cycle
  logic            sgn_a_op, sgn_b_op, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, spec_raw, spec_res;

  always_comb begin
    sgn_a_op = in_op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    sgn_b_op = in_op inside {3'd0, 3'd1, 3'd4, 3'd6};
    a_ext    = in_src1;
    b_ext    = in_src2;
    if (in_word) begin
      a_ext = sgn_a_op ? XLEN'($signed(in_src1[31:0])) : XLEN'(in_src1[31:0]);
      b_ext = sgn_b_op ? XLEN'($signed(in_src2[31:0])) : XLEN'(in_src2[31:0]);
    end
    sa       = sgn_a_op & a_ext[XLEN-1];
    sb       = sgn_b_op & b_ext[XLEN-1];
    mag_a    = sa ? -a_ext : a_ext;
    mag_b    = sb ? -b_ext : b_ext;
    div_zero = in_op[2] && (b_ext == '0);
    div_ovf  = in_op[2] && !in_op[0] && (a_ext == (in_word ? MinNegW : MinNeg)) &&
               (b_ext == '1);
    if (div_zero) spec_raw = in_op[1] ? a_ext : '1;
    else          spec_raw = in_op[1] ? '0 : a_ext;
    spec_res = wsext(spec_raw, in_word);
  end

  // STEP iterations of shift-add (multiply) or restoring division per cycle
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN:0]     sum, rtmp;
  logic              ge;

  always_comb begin
    acc_step = acc_q;
    sum      = '0;
    rtmp     = '0;
    ge       = 1'b0;
    for (int i = 0; i < int'(STEP); i++) begin
      if (!op_q[2]) begin
        sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, a_q} : '0);
        acc_step = {sum, acc_step[XLEN-1:1]};
      end else begin
        rtmp     = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]};
        ge       = rtmp >= {1'b0, a_q};
        acc_step = {ge ? rtmp[XLEN-1:0] - a_q : rtmp[XLEN-1:0], acc_step[XLEN-2:0], ge};
      end
    end
  end

  // Sign correction and result select on the final iteration
  logic [2*XLEN-1:0] prod_full, prod_sgn;
  logic [XLEN-1:0]   div_sel, div_sgn, calc_raw, calc_res;

  always_comb begin
    // W multiplies run 32 steps, leaving the product offset by XLEN-32
    prod_full = word_q ? (acc_step >> (XLEN - 32)) : acc_step;
    prod_sgn  = neg_q ? -prod_full : prod_full;
    div_sel   = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    div_sgn   = neg_q ? -div_sel : div_sel;
    if (op_q[2])              calc_raw = div_sgn;
    else if (op_q[1:0] == '0) calc_raw = prod_sgn[XLEN-1:0];
    else                      calc_raw = prod_sgn[2*XLEN-1:XLEN];
    calc_res = wsext(calc_raw, word_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    a_d      = a_q;
    acc_d    = acc_q;
    result_d = result_q;
    tag_d    = tag_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          op_d   = in_op;
          word_d = in_word;
          tag_d  = in_tag;
          neg_d  = (in_op == 3'd6) ? sa : (sa ^ sb);
          if (in_op[2]) begin
            a_d   = mag_b;
            // W dividends are pre-aligned so their MSB leaves first
            acc_d = {{XLEN{1'b0}}, in_word ? (mag_a << (XLEN - 32)) : mag_a};
          end else begin
            a_d   = mag_a;
            acc_d = {{XLEN{1'b0}}, mag_b};
          end
          if (div_zero || div_ovf) begin
            result_d = spec_res;
            state_d  = StDone;
          end else begin
            cnt_d   = in_word ? CntWord : CntFull;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = calc_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed bench for exu_muldiv (XLEN=64, STEP=1): results, latency, backpressure,
// flush and mid-operation reset.
module tb_exu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_word, flush, out_valid, out_ready, busy;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2, out_result;
  logic [4:0]  in_tag, out_tag;

  int errors = 0;
  int checks = 0;

  exu_muldiv #(.XLEN(64), .STEP(1), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge after the accept edge.
  task automatic start_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag);
    chk("pre_accept_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_word  = w;
    in_src1  = a;
    in_src2  = b;
    in_tag   = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_src1  = ~a;
    in_src2  = ~b;
    in_tag   = ~tag;
    in_op    = ~op;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op(input string name, input logic [63:0] exp, input logic [4:0] tag,
                           input int exp_lat);
    int lat;
    wait_done(lat);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_result"}, out_result, exp);
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_drop_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp, input int exp_lat);
    start_op(op, w, a, b, tag);
    finish_op(name, exp, tag, exp_lat);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_word   = 1'b0;
    in_src1   = '0;
    in_src2   = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_result", out_result, 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'h13,
           64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("mulhu", 3'd3, 1'b0, '1, '1, 5'h01, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("mulhsu", 3'd2, 1'b0, '1, 64'd2, 5'h02, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("div_by_zero", 3'd4, 1'b0, 64'd100, 64'd0, 5'h03, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem_by_zero", 3'd6, 1'b0, 64'd100, 64'd0, 5'h04, 64'd100, 1);
    run_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'h05,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'h06, 64'd0, 1);
    run_op("divw", 3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'h07,
           64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("remw", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'h08,
           64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divuw", 3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'h09,
           64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divu", 3'd5, 1'b0, 64'd1000, 64'd7, 5'h0A, 64'd142, 65);
    run_op("remu", 3'd7, 1'b0, 64'd1000, 64'd7, 5'h0B, 64'd6, 65);

    // Backpressure in DONE
    start_op(3'd0, 1'b0, 64'd6, 64'd9, 5'h1C);
    wait_done(lat);
    chk("bp_latency", 64'(lat), 64'd65);
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", out_result, 64'd54);
      chk("bp_tag", 64'(out_tag), 64'h1C);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    run_op("bp_next", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'h0C,
           64'hFFFF_FFFF_FFFF_FFFA, 65);

    // Flush at CALC cycle 10, with a competing request that must not be taken
    start_op(3'd0, 1'b0, 64'd5, 64'd5, 5'h11);
    repeat (9) @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 3'd4;
    in_src2  = 64'd0;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    chk("flush_no_valid", 64'(seen), 64'd0);

    // Asynchronous reset mid-CALC
    start_op(3'd1, 1'b0, 64'd5, 64'd5, 5'h12);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #2;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_tag", 64'(out_tag), 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    chk("rst_no_valid", 64'(seen), 64'd0);

    run_op("mul_after", 3'd0, 1'b0, 64'd3, 64'd4, 5'h15, 64'd12, 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exu_muldiv.md
Name: exu_muldiv

Overview:
- Parametrised, iterative multiply/divide unit for the execute stage of the RV64 pipeline.
- Covers all RV64M operations:
  - MUL, MULH, MULHSU, MULHU
  - DIV, DIVU, REM, REMU
  - the W (32-bit) forms of each.
- Width and radix are configurable. Input and output use valid/ready handshakes, a tag is carried through, a synchronous flush is supported, and RISC-V divide-by-zero and overflow results are produced in a single cycle.
- Sits between the EXU operand registers and the EXU result mux, and drives the EXU's ready_go.

Parameters:
- XLEN, 64: operand/result width; must be 32 or 64.
- STEP, 1: bits retired per CALC cycle (1, 2 or 4); must divide 32.
- TAG_W, 5: width of the passthrough tag (normally rf_dest).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_word  in  1  W-form operation (32-bit operands, result sign-extended).
- in_src1  in  XLEN  rs1 operand (multiplicand / dividend).
- in_src2  in  XLEN  rs2 operand (multiplier / divisor).
- in_tag  in  TAG_W  passthrough tag.
- flush  in  1  cancel any in-flight operation.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  final result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, counter=0.
  - out_valid=0, out_result=0, out_tag=0, busy=0, in_ready=1.
  - Reset asserted mid-operation discards the operation; no result is ever emitted for it.
- FSM states and handshake:
  - IDLE: in_ready=1. An operation is accepted when in_valid && !flush at the clock edge.
  - Accept latches op, word, tag and preprocessed operands.
  - W form: operands are the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed ops are converted to magnitudes, and the result-sign flags are recorded:
    - MULH: sign(a) ^ sign(b).
    - MULHSU: sign(a) only.
    - DIV: sign(a) ^ sign(b).
    - REM: sign(a).
  - Special cases at accept, next state DONE directly:
    - Divisor==0: quotient = all ones; remainder = dividend (W form: 32-bit dividend, sign-extended).
    - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - Otherwise next state is CALC with counter = N-1, where N = (in_word ? 32 : XLEN) / STEP.
  - CALC:
    - Multiply: shift-add of STEP multiplier bits per cycle into a 2*XLEN accumulator.
    - Divide: STEP restoring-division steps per cycle.
    - Counter decrements; at counter==0 the sign correction (two's-complement negate if the flag is set) and result select are applied, and the result is registered. Next state is DONE.
  - DONE: out_valid=1; out_result and out_tag are held stable until out_ready. On out_valid && out_ready the next state is IDLE. There is no accept in DONE (in_ready=0).
- Latency, accept edge to the first cycle with out_valid=1:
  - Normal operation: N+1 edges (XLEN=64, STEP=1: 65 for 64-bit ops, 33 for W ops).
  - Special cases: 1 edge.
  - Minimum spacing between back-to-back operations: latency plus 1 cycle.
- Result select:
  - MUL: product[XLEN-1:0].
  - MULH, MULHSU, MULHU: product[2XLEN-1:XLEN].
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
  - W forms: result[31:0] sign-extended to XLEN, for both signed and unsigned ops.
- Flush:
  - Synchronous, highest priority. Any state goes to IDLE on the next edge and out_valid drops.
  - A request presented in the same cycle as flush is not accepted.
  - Flush while in DONE with out_ready=1: the result is considered NOT consumed.
- busy = (state != IDLE). busy and out_valid never assert in the same cycle as an accept from IDLE.
- A change on in_* after accept has no effect on the in-flight result.

Test Plan:
- MUL, XLEN=64, STEP=1: src1=7, src2=0xFFFFFFFFFFFFFFFD -> out_result 0xFFFFFFFFFFFFFFEB, out_valid 65 cycles after accept, tag preserved.
- MULHU: 0xFFFFFFFFFFFFFFFF * 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE. MULHSU: -1 * 2 -> 0xFFFFFFFFFFFFFFFF.
- DIV 100/0 -> 0xFFFFFFFFFFFFFFFF and REM 100/0 -> 100, both with 1-cycle latency. DIV 0x8000000000000000 / -1 -> 0x8000000000000000, REM -> 0.
- DIVW src1=0x00000000FFFFFFF9 (low word = -7), src2=2 -> 0xFFFFFFFFFFFFFFFD, latency 33. REMW same operands -> 0xFFFFFFFFFFFFFFFF. DIVUW 0xFFFFFFFF / 1 -> 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_result and out_tag stable and in_ready=0 throughout; raise out_ready -> IDLE next cycle, and a new request is accepted the cycle after.
- Flush at CALC cycle 10, then reset=0 mid-CALC on a second operation -> no out_valid for either operation, IDLE and in_ready=1 on the following cycle, and a subsequent MUL 3*4 returns 12.
